// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: opcodes, FSM states and
// the default step-count width.
package jk_ctrl_pkg;

   localparam int CNT_W_DEF = 4;

   localparam logic [2:0] OP_HOLD   = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_TOGGLE = 3'd4;
   localparam logic [2:0] OP_INC    = 3'd5;
   localparam logic [2:0] OP_DEC    = 3'd6;
   localparam logic [2:0] OP_RSVD   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } state_t;

endpackage

// File: rtl/jk_step_gen.sv
// Combinational J/K and expected-Q generator for one step of a command,
// computed from the bank's current Q.
module jk_step_gen
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] exp_val
);

   logic [WIDTH-1:0] t_inc;
   logic [WIDTH-1:0] t_dec;
   logic             c_inc;
   logic             c_dec;

   // A bit toggles on increment when all lower bits are 1, on decrement when all are 0.
   always_comb begin
      t_inc = '0;
      t_dec = '0;
      c_inc = 1'b1;
      c_dec = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t_inc[i] = c_inc;
         t_dec[i] = c_dec;
         c_inc    = c_inc & q[i];
         c_dec    = c_dec & ~q[i];
      end
   end

   always_comb begin
      // NOTE: defaults before the case keep every output assigned on every path, so no latch is inferred.
      j       = '0;
      k       = '0;
      exp_val = q;
      case (op)
         OP_CLEAR:  begin k = '1;                  exp_val = '0;           end
         OP_SET:    begin j = '1;                  exp_val = '1;           end
         OP_LOAD:   begin j = data;  k = ~data;    exp_val = data;         end
         OP_TOGGLE: begin j = data;  k = data;     exp_val = q ^ data;     end
         OP_INC:    begin j = t_inc; k = t_inc;    exp_val = q + 1'b1;     end
         OP_DEC:    begin j = t_dec; k = t_dec;    exp_val = q - 1'b1;     end
         default:   ;
      endcase
   end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for an adjacent JK flip-flop bank: drives J/K one cycle per
// step, verifies Q after each step and reports done/err/result.
module jk_bank_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   state_t           state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] exp_r;
   logic [CNT_W-1:0] remaining;

   logic [2:0]       gen_op;
   logic [WIDTH-1:0] gen_data;
   logic [WIDTH-1:0] gen_j;
   logic [WIDTH-1:0] gen_k;
   logic [WIDTH-1:0] gen_exp;
   logic             accept;
   logic             multi;

   assign accept   = cmd_valid && cmd_ready;
   assign multi    = (cmd_op == OP_INC) || (cmd_op == OP_DEC);
   // In IDLE the first step comes straight from the command; later steps reuse the captured one.
   assign gen_op   = (state == ST_IDLE) ? cmd_op   : op_r;
   assign gen_data = (state == ST_IDLE) ? cmd_data : data_r;

   jk_step_gen #(.WIDTH(WIDTH)) u_step_gen (
      .op      (gen_op),
      .q       (q_in),
      .data    (gen_data),
      .j       (gen_j),
      .k       (gen_k),
      .exp_val (gen_exp)
   );

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         op_r      <= OP_HOLD;
         data_r    <= '0;
         exp_r     <= '0;
         remaining <= '0;
         j_out     <= '0;
         k_out     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         result    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_r      <= cmd_op;
                  data_r    <= cmd_data;
                  remaining <= (multi && cmd_steps != '0) ? cmd_steps - 1'b1 : '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  if (cmd_op == OP_RSVD) begin
                     err    <= 1'b1;
                     done   <= 1'b1;
                     result <= q_in;
                     state  <= ST_DONE;
                  end else begin
                     j_out <= gen_j;
                     k_out <= gen_k;
                     exp_r <= gen_exp;
                     state <= ST_DRIVE;
                  end
               end
            end
            ST_DRIVE: begin
               j_out <= '0;
               k_out <= '0;
               state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (q_in != exp_r) begin
                  err    <= 1'b1;
                  done   <= 1'b1;
                  result <= q_in;
                  state  <= ST_DONE;
               end else if (remaining != '0) begin
                  remaining <= remaining - 1'b1;
                  j_out     <= gen_j;
                  k_out     <= gen_k;
                  exp_r     <= gen_exp;
                  state     <= ST_DRIVE;
               end else begin
                  done   <= 1'b1;
                  result <= q_in;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a behavioural JK bank; directed
// scenarios followed by randomized commands against an arithmetic model.
module tb_jk_bank_ctrl;
   import jk_ctrl_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_steps;
   logic [WIDTH-1:0] q_in;
   logic [WIDTH-1:0] j_out;
   logic [WIDTH-1:0] k_out;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;

   logic [WIDTH-1:0] bank_q;
   logic [WIDTH-1:0] bank_set_val;
   logic             bank_set_en;
   logic             corrupt;

   typedef struct {
      logic             err;
      logic [WIDTH-1:0] result;
      int               lat;
   } exp_t;

   exp_t                 sb[$];
   int                   acc_q[$];
   logic [2*WIDTH-1:0]   jk_q[$];

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int cycle_cnt = 0;

   exp_t               mon_e;
   int                 mon_a;
   logic [2*WIDTH-1:0] mon_jk;

   jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .q_in      (q_in),
      .j_out     (j_out),
      .k_out     (k_out),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // The JK bank itself, with a preset path and an optional bit-0 fault on its Q.
   always @(posedge clk) begin
      if (bank_set_en) bank_q <= bank_set_val;
      else             bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
   end
   assign q_in = bank_q ^ {{(WIDTH-1){1'b0}}, corrupt};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
   endtask

   // Monitor: every J/K activity and every done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (j_out != '0 || k_out != '0) begin
         if (jk_q.size() == 0) fail_now("extra_drive", {j_out, k_out});
         else begin
            mon_jk = jk_q.pop_front();
            check("drive_jk", {j_out, k_out}, mon_jk);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0 || acc_q.size() == 0) fail_now("unexpected_done", result);
         else begin
            mon_e = sb.pop_front();
            mon_a = acc_q.pop_front();
            check("err", err, mon_e.err);
            check("result", result, mon_e.result);
            check("latency", cycle_cnt - mon_a + 1, mon_e.lat);
         end
      end
   end

   // Reference model: final value by plain arithmetic, per-step masks as q ^ next_q.
   task automatic plan(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] steps, input logic [WIDTH-1:0] q0,
                       input bit bad_q);
      exp_t             e;
      int               n;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] nq;
      logic [WIDTH-1:0] all1;
      logic [WIDTH-1:0] zero;
      all1 = '1;
      zero = '0;
      n = (steps == 0) ? 1 : int'(steps);
      e.err = 1'b0;
      e.lat = 3;
      e.result = q0;
      case (op)
         OP_HOLD:   e.result = q0;
         OP_CLEAR:  begin e.result = zero;      jk_q.push_back({zero, all1}); end
         OP_SET:    begin e.result = all1;      jk_q.push_back({all1, zero}); end
         OP_LOAD:   begin e.result = data;      jk_q.push_back({data, ~data}); end
         OP_TOGGLE: begin
            e.result = q0 ^ data;
            if (data != 0) jk_q.push_back({data, data});
         end
         OP_INC, OP_DEC: begin
            e.result = (op == OP_INC) ? q0 + WIDTH'(n) : q0 - WIDTH'(n);
            e.lat = 2 * n + 1;
            q = q0;
            for (int s = 0; s < n; s++) begin
               nq = (op == OP_INC) ? q + 1'b1 : q - 1'b1;
               jk_q.push_back({q ^ nq, q ^ nq});
               q = nq;
            end
         end
         default: begin e.err = 1'b1; e.lat = 1; end
      endcase
      if (bad_q) begin
         e.err = 1'b1;
         e.result = e.result ^ {{(WIDTH-1){1'b0}}, 1'b1};
      end
      sb.push_back(e);
   endtask

   task automatic preset_bank(input logic [WIDTH-1:0] v);
      @(negedge clk);
      bank_set_val = v;
      bank_set_en  = 1'b1;
      @(negedge clk);
      bank_set_en  = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] steps, input bit bad_q);
      bit got;
      @(negedge clk);
      plan(op, data, steps, bank_q, bad_q);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_steps = steps;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) fail_now("ready_timeout", {31'b0, cmd_ready});
      @(posedge clk);
      #1;
      acc_q.push_back(cycle_cnt);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_data  = WIDTH'($urandom);
      cmd_steps = CNT_W'($urandom);
      if (bad_q) begin
         @(posedge clk);
         #1 corrupt = 1'b1;
      end
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      if (!got) fail_now("done_timeout", {31'b0, done});
   endtask

   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] steps, input bit bad_q);
      send(op, data, steps, bad_q);
      wait_done();
      corrupt = 1'b0;
   endtask

   initial begin
      int dc;
      reset        = 1'b0;
      cmd_valid    = 1'b1;
      cmd_op       = OP_LOAD;
      cmd_data     = 4'b1111;
      cmd_steps    = '0;
      corrupt      = 1'b0;
      bank_set_en  = 1'b1;
      bank_set_val = '0;

      // Reset held two cycles with a command pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_j", j_out, 0);
      check("rst_k", k_out, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      bank_set_en = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1);
      cmd_valid = 1'b0;

      // LOAD 1010 from 0000.
      preset_bank(4'b0000);
      issue(OP_LOAD, 4'b1010, 4'd0, 1'b0);

      // INC x3 from 1110 wraps through 1111, 0000 to 0001.
      preset_bank(4'b1110);
      issue(OP_INC, 4'b0000, 4'd3, 1'b0);
      check("inc_bank_q", bank_q, 4'b0001);

      // TOGGLE with a faulted Q bit during the check cycle.
      preset_bank(4'b0011);
      issue(OP_TOGGLE, 4'b0110, 4'd0, 1'b1);

      // Reserved opcode: immediate done with err, ready again next cycle.
      issue(OP_RSVD, 4'b1001, 4'd0, 1'b0);
      @(negedge clk);
      check("ready_after_rsvd", cmd_ready, 1);

      // DEC x5 aborted by reset during the second drive.
      preset_bank(4'b0010);
      send(OP_DEC, 4'b0000, 4'd5, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      acc_q.delete();
      jk_q.delete();
      @(negedge clk);
      check("abort_j", j_out, 0);
      check("abort_k", k_out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      dc = done_cnt;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (12) @(negedge clk);
      check("no_done_after_abort", done_cnt, dc);
      check("abort_ready", cmd_ready, 1);
      issue(OP_CLEAR, 4'b0000, 4'd0, 1'b0);

      // Randomized commands.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) preset_bank(WIDTH'($urandom));
         issue(3'($urandom_range(0, 7)), WIDTH'($urandom), CNT_W'($urandom), 1'b0);
      end

      repeat (3) @(negedge clk);
      check("sb_left", sb.size(), 0);
      check("jk_left", jk_q.size(), 0);
      check("acc_left", acc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
